// File: rtl/sipo_pkg.sv
// ---------------------------------------------------------------------------
// sipo_pkg
// Shared types and constants for the serial receive path. Both the receive
// controller and the transmit controller use this package, so both ends of
// the link agree on the frame width and on the bit-order encoding.
//
// Contents:
//   SIPO_WIDTH      default frame / parallel word width
//   MODE_MSB_FIRST  mode_select value for MSB-first frames
//   MODE_LSB_FIRST  mode_select value for LSB-first frames
//   rx_state_t      receive FSM states (IDLE, RECV)
// ---------------------------------------------------------------------------
package sipo_pkg;

    localparam int   SIPO_WIDTH     = 8;
    localparam logic MODE_MSB_FIRST = 1'b0;
    localparam logic MODE_LSB_FIRST = 1'b1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_t;

endpackage : sipo_pkg

// File: rtl/sipo_shift_reg.sv
// ---------------------------------------------------------------------------
// sipo_shift_reg
// Direction-selectable serial-in shift register used to assemble a frame.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset, clears q
//   clr    synchronous clear (frame restart), has priority over en
//   en     shift enable; din is taken in on cycles where it is 1
//   dir    MODE_MSB_FIRST: shift left, din into bit 0
//          MODE_LSB_FIRST: shift right, din into bit WIDTH-1
//   din    serial data bit
//   q      current register contents
// ---------------------------------------------------------------------------
module sipo_shift_reg
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             dir,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // Shift register: clear on reset or restart, otherwise shift when enabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (en) begin
            if (dir == MODE_LSB_FIRST) begin
                r_q <= {din, r_q[WIDTH-1:1]};
            end else begin
                r_q <= {r_q[WIDTH-2:0], din};
            end
        end else begin
            r_q <= r_q;
        end
    end

    assign q = r_q;

endmodule : sipo_shift_reg

// File: rtl/sipo_rx_ctrl.sv
// ---------------------------------------------------------------------------
// sipo_rx_ctrl
// Receive-side controller for the PISO serial link. A start strobe opens a
// frame, each shift_in strobe captures one din bit, and after WIDTH bits the
// assembled word is moved to a separate output register and offered on a
// valid/ready interface. Framing (start mid-frame) and overrun (completed
// word dropped because the previous one is still pending) are flagged on
// sticky error outputs that clear on clr_err.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   start        frame start strobe
//   mode_select  bit order, latched on start (0 MSB-first, 1 LSB-first)
//   shift_in     bit-valid strobe
//   din          serial data bit
//   data_ready   consumer accepts data_out while data_valid=1
//   clr_err      clears overrun_err / frame_err (a same-cycle error wins)
//   data_out     assembled word, stable while data_valid=1
//   data_valid   a word is pending
//   busy         frame in progress
//   overrun_err  sticky: a completed word was dropped
//   frame_err    sticky: start arrived with a partial frame in progress
// ---------------------------------------------------------------------------
module sipo_rx_ctrl
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode_select,
    input  logic             shift_in,
    input  logic             din,
    input  logic             data_ready,
    input  logic             clr_err,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             overrun_err,
    output logic             frame_err
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    rx_state_t        r_state;
    rx_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_mode;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_word;
    logic             w_cap;
    logic             w_done;
    logic             w_frame_evt;
    logic             w_overrun_evt;
    logic             w_load;
    logic [WIDTH-1:0] r_data_out;
    logic             r_data_valid;
    logic             r_overrun_err;
    logic             r_frame_err;

    // start has priority over shift_in, so a bit strobed with start is lost.
    assign w_cap         = (r_state == RECV) && shift_in && !start;
    assign w_done        = w_cap && (r_bit_cnt == CNT_W'(WIDTH - 1));
    assign w_frame_evt   = (r_state == RECV) && start && (r_bit_cnt != '0);
    assign w_overrun_evt = w_done && r_data_valid && !data_ready;
    assign w_load        = w_done && (!r_data_valid || data_ready);

    // The shift register only holds WIDTH-1 bits at completion; the last bit
    // is merged here so the full word lands in the output register on the
    // same edge that captures it.
    assign w_word = (r_mode == MODE_LSB_FIRST) ? {din, w_q[WIDTH-1:1]}
                                               : {w_q[WIDTH-2:0], din};

    sipo_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .en    (w_cap),
        .dir   (r_mode),
        .din   (din),
        .q     (w_q)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RECV;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RECV: begin
                if (start) begin
                    w_state_nxt = RECV;
                end else if (w_done) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = RECV;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FSM output decode.
    always_comb begin
        busy = 1'b0;
        case (r_state)
            IDLE:    busy = 1'b0;
            RECV:    busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Bit counter and latched bit order; start (re)opens a frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_mode    <= MODE_MSB_FIRST;
        end else if (start) begin
            r_bit_cnt <= '0;
            r_mode    <= mode_select;
        end else if (w_cap) begin
            r_bit_cnt <= w_done ? '0 : (r_bit_cnt + CNT_W'(1));
            r_mode    <= r_mode;
        end else begin
            r_bit_cnt <= r_bit_cnt;
            r_mode    <= r_mode;
        end
    end

    // Output word register and valid/ready handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else if (w_load) begin
            r_data_out   <= w_word;
            r_data_valid <= 1'b1;
        end else if (r_data_valid && data_ready) begin
            r_data_out   <= r_data_out;
            r_data_valid <= 1'b0;
        end else begin
            r_data_out   <= r_data_out;
            r_data_valid <= r_data_valid;
        end
    end

    // Sticky error flags; an event in the clr_err cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overrun_err <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            if (w_overrun_evt) begin
                r_overrun_err <= 1'b1;
            end else if (clr_err) begin
                r_overrun_err <= 1'b0;
            end else begin
                r_overrun_err <= r_overrun_err;
            end
            if (w_frame_evt) begin
                r_frame_err <= 1'b1;
            end else if (clr_err) begin
                r_frame_err <= 1'b0;
            end else begin
                r_frame_err <= r_frame_err;
            end
        end
    end

    assign data_out    = r_data_out;
    assign data_valid  = r_data_valid;
    assign overrun_err = r_overrun_err;
    assign frame_err   = r_frame_err;

endmodule : sipo_rx_ctrl
